// File: rtl/result_tx_pkg.sv
// Shared types and defaults for the result stream transmitter.
package result_tx_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_FRAME_LEN  = 8;

  // Wide enough for any stream up to 1024 bits; users slice DATA_W/8 bits.
  localparam int TKEEP_MAX_W = 128;
  localparam logic [TKEEP_MAX_W-1:0] TKEEP_ALL_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through result buffer. The head is the registered word at
// the read pointer; a word written at an edge appears at the head only after
// that edge (no write-to-read bypass).
module result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  // Qualify requests, advance power-of-two pointers and track occupancy.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the occupancy says empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/result_stream_tx.sv
// Buffers accumulator results and sends them as fixed-length AXI-Stream
// frames to the DMA write channel, with a frame-done interrupt and a sticky
// overflow flag for results lost while the buffer was full.
module result_stream_tx
  import result_tx_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FRAME_LEN  = DEF_FRAME_LEN
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_data_valid,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  o_intr,
  output logic                  o_overflow
);

  localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  tx_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              overflow_q, overflow_d;

  logic              fifo_empty, fifo_full;
  logic [DATA_W-1:0] fifo_head;
  logic              stream_valid;
  logic              handshake;
  logic              push;
  logic              drop;

  // Handshake: a beat transfers at a rising edge where tvalid and tready are
  // both high. tvalid depends only on registered state, so once raised it
  // holds (with tdata/tlast) until that edge; only a handshake pops the head.
  assign stream_valid = (state_q == ST_STREAM) && !fifo_empty;
  assign handshake    = stream_valid && m_axis_tready;

  // A full buffer still takes a result when the head leaves in the same cycle.
  assign push = i_data_valid && (!fifo_full || handshake);
  assign drop = i_data_valid && fifo_full && !handshake;

  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .push      (push),
    .push_data (i_data),
    .pop       (handshake),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign m_axis_tdata = fifo_head;
  assign m_axis_tkeep = TKEEP_ALL_ONES[DATA_W/8-1:0];
  assign o_overflow   = overflow_q;

  // Frame FSM: next state, beat counting and stream/interrupt outputs.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    o_intr        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // An empty buffer mid-frame just stalls; the beat count is kept.
        m_axis_tvalid = stream_valid;
        m_axis_tlast  = stream_valid && (beat_q == LAST_BEAT);
        if (handshake) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_DONE: begin
        o_intr  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Overflow stays set from the first dropped result until reset.
  always_comb begin
    overflow_d = overflow_q | drop;
  end

  // State, beat count and overflow registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_result_stream_tx.sv
// Directed bench for result_stream_tx: basic frame, back-pressure, overflow,
// full-with-pop, mid-frame gap and reset mid-frame.
module tb_result_stream_tx;

  localparam int DATA_W = 32;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  logic [DATA_W-1:0]   i_data;
  logic                i_data_valid;
  logic [DATA_W-1:0]   m_axis_tdata;
  logic [DATA_W/8-1:0] m_axis_tkeep;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                m_axis_tlast;
  logic                o_intr;
  logic                o_overflow;

  result_stream_tx #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (8),
    .FRAME_LEN  (8)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_data        (i_data),
    .i_data_valid  (i_data_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .o_intr        (o_intr),
    .o_overflow    (o_overflow)
  );

  // ---------------- scoreboard state ----------------
  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic              exp_last_q[$];
  logic [DATA_W-1:0] rx_data[$];
  logic              rx_last[$];

  int intr_cnt;
  int intr_cyc;
  int last_hs_cyc;
  int first_valid_cyc;
  int stall_checks;
  logic              prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic new_test();
    exp_q.delete();
    exp_last_q.delete();
    rx_data.delete();
    rx_last.delete();
    intr_cnt        = 0;
    intr_cyc        = -1;
    last_hs_cyc     = -1;
    first_valid_cyc = -1;
    stall_checks    = 0;
    prev_stall      = 1'b0;
  endtask

  // Expected frame: words base..base+n-1, tlast only at index last_idx.
  task automatic expect_words(input int base, input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(DATA_W'(base + i));
      exp_last_q.push_back(i == last_idx);
    end
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, 32'(rx_data.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), rx_data[i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), 32'(rx_last[i]), 32'(exp_last_q[i]));
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, observe outputs mid-cycle, then
  // advance through the next rising edge to the following falling edge.
  task automatic step(input logic dv, input logic [DATA_W-1:0] d, input logic rdy);
    i_data_valid  = dv;
    i_data        = d;
    m_axis_tready = rdy;
    #1;
    if (prev_stall) begin
      stall_checks++;
      check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("stall_tdata", m_axis_tdata, prev_data);
      check("stall_tlast", 32'(m_axis_tlast), 32'(prev_last));
    end
    if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (m_axis_tvalid && m_axis_tready) begin
      rx_data.push_back(m_axis_tdata);
      rx_last.push_back(m_axis_tlast);
      last_hs_cyc = cyc;
    end
    if (o_intr) begin
      intr_cnt++;
      intr_cyc = cyc;
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic do_reset();
    i_rst        = 1'b0;
    i_data_valid = 1'b0;
    prev_stall   = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
  endtask

  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // ---------------- directed sequence ----------------
  initial begin
    int c0;
    i_rst         = 1'b0;
    i_data        = '0;
    i_data_valid  = 1'b0;
    m_axis_tready = 1'b0;
    new_test();

    // Reset state
    #2;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_intr", 32'(o_intr), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    check("rst_tkeep", 32'(m_axis_tkeep), 32'h0000_000f);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);

    // Basic frame: words 1..8, tready held high
    new_test();
    c0 = cyc;
    for (int k = 1; k <= 8; k++) step(1'b1, DATA_W'(k), 1'b1);
    for (int k = 0; k < 12; k++) step(1'b0, '0, 1'b1);
    expect_words(1, 8, 7);
    compare_frame("basic");
    check("basic_latency", 32'(first_valid_cyc - c0), 32'd2);
    check("basic_intr_cnt", 32'(intr_cnt), 32'd1);
    check("basic_intr_time", 32'(intr_cyc), 32'(last_hs_cyc + 1));
    check("basic_overflow", 32'(o_overflow), 32'd0);

    // Back-pressure: tready pattern 1,0,0,1 repeating
    new_test();
    for (int k = 0; k < 8; k++) step(1'b1, DATA_W'(21 + k), pat[k % 4]);
    for (int k = 8; k < 48; k++) step(1'b0, '0, pat[k % 4]);
    expect_words(21, 8, 7);
    compare_frame("bp");
    check("bp_stalls_seen", 32'(stall_checks > 0), 32'd1);
    check("bp_intr_cnt", 32'(intr_cnt), 32'd1);

    // Overflow: nine words with tready low, the ninth is dropped
    do_reset();
    new_test();
    for (int k = 0; k < 8; k++) step(1'b1, DATA_W'(10 + k), 1'b0);
    check("ovf_before_drop", 32'(o_overflow), 32'd0);
    check("ovf_head", m_axis_tdata, 32'd10);
    step(1'b1, DATA_W'(18), 1'b0);
    check("ovf_set", 32'(o_overflow), 32'd1);
    for (int k = 0; k < 20; k++) step(1'b0, '0, 1'b1);
    expect_words(10, 8, 7);
    compare_frame("ovf");
    check("ovf_intr_cnt", 32'(intr_cnt), 32'd1);
    check("ovf_sticky", 32'(o_overflow), 32'd1);

    // Full buffer with a pop in the same cycle as a write
    do_reset();
    check("full_ovf_cleared", 32'(o_overflow), 32'd0);
    new_test();
    for (int k = 0; k < 8; k++) step(1'b1, DATA_W'(31 + k), 1'b0);
    step(1'b1, DATA_W'(39), 1'b1);
    for (int k = 0; k < 20; k++) step(1'b0, '0, 1'b1);
    expect_words(31, 9, 7);
    compare_frame("fullpop");
    check("fullpop_overflow", 32'(o_overflow), 32'd0);
    check("fullpop_intr_cnt", 32'(intr_cnt), 32'd1);

    // Mid-frame gap: 3 words, 5 idle cycles, 5 words
    do_reset();
    new_test();
    for (int k = 0; k < 3; k++) step(1'b1, DATA_W'(41 + k), 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k >= 2) check($sformatf("gap_tvalid%0d", k), 32'(m_axis_tvalid), 32'd0);
      step(1'b0, '0, 1'b1);
    end
    check("gap_partial_beats", 32'(rx_data.size()), 32'd3);
    check("gap_no_intr", 32'(intr_cnt), 32'd0);
    for (int k = 0; k < 5; k++) step(1'b1, DATA_W'(44 + k), 1'b1);
    for (int k = 0; k < 12; k++) step(1'b0, '0, 1'b1);
    expect_words(41, 8, 7);
    compare_frame("gap");
    check("gap_intr_cnt", 32'(intr_cnt), 32'd1);

    // Reset mid-frame after beat 4
    do_reset();
    new_test();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, DATA_W'(51 + k), 1'b1);
      if (rx_data.size() == 4) break;
    end
    expect_words(51, 4, -1);
    compare_frame("pre_rst");
    i_data_valid = 1'b0;
    #1;
    check("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    #1;
    i_rst = 1'b0;
    #1;
    check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("midrst_tlast", 32'(m_axis_tlast), 32'd0);
    check("midrst_intr", 32'(o_intr), 32'd0);
    check("midrst_overflow", 32'(o_overflow), 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    new_test();
    for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1);
    check("midrst_no_intr", 32'(intr_cnt), 32'd0);
    check("midrst_flushed", 32'(rx_data.size()), 32'd0);
    for (int k = 0; k < 8; k++) step(1'b1, DATA_W'(61 + k), 1'b1);
    for (int k = 0; k < 12; k++) step(1'b0, '0, 1'b1);
    expect_words(61, 8, 7);
    compare_frame("postrst");
    check("postrst_intr_cnt", 32'(intr_cnt), 32'd1);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
